// File: rtl/uart_tx_if.sv
// Transmit-side bundle between the APB register block and the UART TX engine.
// Carries frame data, frame config and the start strobe toward the engine, and
// returns the serial line and the tx-done status.
interface uart_tx_if;
    logic [31:0] tx_data_i;
    logic [1:0]  data_bit_num_i;
    logic        stop_bit_num_i;
    logic        parity_en_i;
    logic        parity_type_i;
    logic        start_tx_i;
    logic        tx_o;
    logic        tx_done_o;

    // Register-block side.
    modport master (
        output tx_data_i, data_bit_num_i, stop_bit_num_i,
               parity_en_i, parity_type_i, start_tx_i,
        input  tx_o, tx_done_o
    );

    // Transmit-engine side.
    modport slave (
        input  tx_data_i, data_bit_num_i, stop_bit_num_i,
               parity_en_i, parity_type_i, start_tx_i,
        output tx_o, tx_done_o
    );
endinterface

// File: rtl/uart_tx.sv
// UART serial transmit engine.
// Frames: 1 start bit, 5..8 data bits LSB first, optional even/odd parity,
// 1 or 2 stop bits. Bit timing comes from an internal clock-divider counter.
// A frame is triggered by a rising edge of start_tx_i seen while idle; the
// frame config is captured at that edge so later input changes are harmless.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input logic   clk,
    input logic   reset,
    uart_tx_if.slave bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_n;
    logic [2:0]       bit_idx_q, bit_idx_n;
    logic             stop_cnt_q, stop_cnt_n;
    logic             tx_q, tx_n;
    logic             done_q, done_n;
    logic             start_d;
    logic             trigger;
    logic             period_end;

    // Frame shadow copies; only meaningful once a frame has been triggered.
    logic [7:0]       sh_data;
    logic [1:0]       sh_nbits;
    logic             sh_stop;
    logic             sh_pen;
    logic             sh_par;

    // Bits above the widest frame are never transmitted.
    logic             unused_data_hi;
    assign unused_data_hi = ^bus.tx_data_i[31:8];

    // Parity over the low N data bits; odd parity is even parity inverted.
    function automatic logic parity_calc(input logic [7:0] data,
                                         input logic [1:0] nbits,
                                         input logic       odd);
        logic [7:0] mask;
        case (nbits)
            2'b00:   mask = 8'h1F;
            2'b01:   mask = 8'h3F;
            2'b10:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        return (^(data & mask)) ^ odd;
    endfunction

    assign trigger    = (state_q == IDLE) && bus.start_tx_i && !start_d;
    assign period_end = (clk_cnt_q == CNT_MAX);

    assign bus.tx_o      = tx_q;
    assign bus.tx_done_o = done_q;

    // Control state: FSM, counters, line and done registers, start edge delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b1;
            start_d    <= 1'b0;
        end else begin
            state_q    <= state_n;
            clk_cnt_q  <= clk_cnt_n;
            bit_idx_q  <= bit_idx_n;
            stop_cnt_q <= stop_cnt_n;
            tx_q       <= tx_n;
            done_q     <= done_n;
            start_d    <= bus.start_tx_i;
        end
    end

    // Capture data and frame config on the triggering edge.
    always_ff @(posedge clk) begin
        if (trigger) begin
            sh_data  <= bus.tx_data_i[7:0];
            sh_nbits <= bus.data_bit_num_i;
            sh_stop  <= bus.stop_bit_num_i;
            sh_pen   <= bus.parity_en_i;
            sh_par   <= parity_calc(bus.tx_data_i[7:0], bus.data_bit_num_i,
                                    bus.parity_type_i);
        end
    end

    // Next-state logic; tx_n is the line level for the cycle after the edge.
    always_comb begin
        state_n    = state_q;
        clk_cnt_n  = clk_cnt_q;
        bit_idx_n  = bit_idx_q;
        stop_cnt_n = stop_cnt_q;
        tx_n       = tx_q;
        done_n     = done_q;

        if (state_q != IDLE) begin
            clk_cnt_n = period_end ? '0 : clk_cnt_q + CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                tx_n   = 1'b1;
                done_n = 1'b1;
                if (trigger) begin
                    state_n    = START;
                    tx_n       = 1'b0;
                    done_n     = 1'b0;
                    clk_cnt_n  = '0;
                    bit_idx_n  = '0;
                    stop_cnt_n = 1'b0;
                end
            end
            START: begin
                if (period_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                    tx_n      = sh_data[0];
                end
            end
            DATA: begin
                if (period_end) begin
                    // Last data index is N-1 = 4 + data_bit_num.
                    if (bit_idx_q == {1'b1, sh_nbits}) begin
                        if (sh_pen) begin
                            state_n = PARITY;
                            tx_n    = sh_par;
                        end else begin
                            state_n    = STOP;
                            stop_cnt_n = 1'b0;
                            tx_n       = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx_q + 3'd1;
                        tx_n      = sh_data[bit_idx_n];
                    end
                end
            end
            PARITY: begin
                if (period_end) begin
                    state_n    = STOP;
                    stop_cnt_n = 1'b0;
                    tx_n       = 1'b1;
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (period_end) begin
                    if (stop_cnt_q == sh_stop) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                done_n  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT = 4. Inputs change on the
// falling clock edge; outputs are sampled on the falling edge too.
module tb_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    uart_tx_if bus();

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Present config and raise start at a falling edge; returns one cycle later,
    // just after the edge that samples the start request.
    task automatic start_frame(input logic [7:0] data, input logic [1:0] nb,
                               input logic stop2, input logic pen,
                               input logic ptype, input bit hold);
        bus.tx_data_i      = {24'hA5C3E1, data};
        bus.data_bit_num_i = nb;
        bus.stop_bit_num_i = stop2;
        bus.parity_en_i    = pen;
        bus.parity_type_i  = ptype;
        bus.start_tx_i     = 1'b1;
        @(negedge clk);
        if (!hold) bus.start_tx_i = 1'b0;
    endtask

    // Cycle c counts falling edges after the trigger edge. Line bit k is
    // checked at c = 4k+2; the frame length is the first c with done high.
    // Returns on the falling edge where done was first seen high.
    task automatic capture(input string tag, input logic [15:0] exp_bits,
                           input int nbits, input int exp_len, input int poke_c);
        int found;
        found = -1;
        check({tag, "_busy"}, bus.tx_done_o, 0);
        for (int c = 0; c <= exp_len + 8; c++) begin
            if ((c % CPB) == 2 && (c / CPB) < nbits)
                check($sformatf("%s_bit%0d", tag, c / CPB), bus.tx_o, exp_bits[c / CPB]);
            if (c > 0 && bus.tx_done_o === 1'b1) begin
                found = c;
                break;
            end
            if (c == poke_c) begin
                bus.data_bit_num_i = 2'b00;
                bus.tx_data_i      = 32'h0;
                bus.start_tx_i     = 1'b1;
            end
            @(negedge clk);
        end
        check({tag, "_len"}, found, exp_len);
    endtask

    task automatic idle_check(input string tag, input int n);
        logic bad;
        bad = 1'b0;
        repeat (n) begin
            if (bus.tx_o !== 1'b1 || bus.tx_done_o !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        check(tag, bad, 0);
    endtask

    initial begin
        reset              = 1'b1;
        bus.tx_data_i      = 32'h0;
        bus.data_bit_num_i = 2'b11;
        bus.stop_bit_num_i = 1'b0;
        bus.parity_en_i    = 1'b0;
        bus.parity_type_i  = 1'b0;
        bus.start_tx_i     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx", bus.tx_o, 1);
        check("rst_done", bus.tx_done_o, 1);
        reset = 1'b0;
        idle_check("post_rst_idle", 3);

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        capture("8n1", 16'h034A, 10, 40, -1);
        idle_check("8n1_idle", 2);

        // 8E1 then 8O1 back to back at the earliest possible edge.
        start_frame(8'hA5, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        capture("8e1", 16'h054A, 11, 44, -1);
        start_frame(8'hA5, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        capture("8o1", 16'h074A, 11, 44, -1);
        idle_check("8o1_idle", 2);

        // 5E2 0xFF: 0,1,1,1,1,1,1,1,1
        start_frame(8'hFF, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        capture("5e2", 16'h01FE, 9, 36, -1);
        idle_check("5e2_idle", 2);

        // 7N2 0x35: 0,1,0,1,0,1,1,0,1,1
        start_frame(8'h35, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        capture("7n2", 16'h036A, 10, 40, -1);
        idle_check("7n2_idle", 2);

        // 6O1 0x2C: 0,0,0,1,1,0,1,0,1
        start_frame(8'h2C, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
        capture("6o1", 16'h0158, 9, 36, -1);
        idle_check("6o1_idle", 2);

        // Start edge plus config change at cycle 10 of an 8N1 frame.
        start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        capture("chg", 16'h034A, 10, 40, 10);
        idle_check("chg_noretrig", 8);
        bus.start_tx_i = 1'b0;
        idle_check("chg_idle", 2);

        // Start held high across the end of the frame.
        start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        capture("hold", 16'h034A, 10, 40, -1);
        idle_check("hold_noretrig", 8);
        bus.start_tx_i = 1'b0;
        idle_check("hold_idle", 2);

        // Asynchronous reset at cycle 15 of a frame.
        start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        check("rst_mid_busy", bus.tx_done_o, 0);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_tx", bus.tx_o, 1);
        check("rst_mid_done", bus.tx_done_o, 1);
        @(negedge clk);
        reset = 1'b0;
        idle_check("rst_mid_idle", 12);

        // A fresh frame still works after the abandoned one.
        start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        capture("after_rst", 16'h034A, 10, 40, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
